// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_pkg: shared definitions for the multi-cycle RV32I control sequencer.
//   - RV32I major opcode constants (instruction bits [6:0])
//   - sequencer state encoding
//   - instruction class produced by inst_class
//   - halt cause codes driven on the fault output
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OP_IMM,
        CLS_OP,
        CLS_FENCE,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } inst_class_t;

    typedef enum logic [1:0] {
        FAULT_ECALL   = 2'd0,
        FAULT_ILLEGAL = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } fault_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: bundle between the control sequencer and its memories/datapath.
//   imem_req/imem_ready/imem_inst : instruction fetch handshake and data
//   dmem_req/dmem_we/dmem_ready   : data memory handshake (we=1 store, 0 load)
//   ir                            : latched instruction word for the decoder
//   br_taken                      : branch condition from the alu
//   rf_we/pc_en/pc_sel_target     : regfile write and pc update strobes
// master = sequencer side, slave = memory/datapath side.
interface cpu_ctrl_fsm_if;

    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_inst;
    logic [31:0] ir;
    logic        br_taken;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic        pc_en;
    logic        pc_sel_target;

    modport master (
        output imem_req,
        input  imem_ready,
        input  imem_inst,
        output ir,
        input  br_taken,
        output dmem_req,
        output dmem_we,
        input  dmem_ready,
        output rf_we,
        output pc_en,
        output pc_sel_target
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        output imem_inst,
        input  ir,
        output br_taken,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready,
        input  rf_we,
        input  pc_en,
        input  pc_sel_target
    );

endinterface

// File: rtl/cpu_ctrl_fsm_inst_class.sv
// inst_class: combinational classification of the latched instruction.
//   opcode    in  7  instruction bits [6:0]
//   funct3    in  3  instruction bits [14:12]
//   cls       out    instruction class (CLS_ILLEGAL for anything unsupported)
//   writes_rd out 1  class writes a destination register
//   is_mem    out 1  class needs the MEM phase (load or store)
//   is_store  out 1  class is a store
module inst_class
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output inst_class_t cls,
    output logic        writes_rd,
    output logic        is_mem,
    output logic        is_store
);

    // Opcode map. Words whose low two bits are not 2'b11 never match a
    // listed opcode, so they fall through to CLS_ILLEGAL. Only ECALL/EBREAK
    // (funct3=0) are accepted from the SYSTEM space; CSR ops are illegal.
    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_OP:     cls = CLS_OP;
            OPC_FENCE:  cls = CLS_FENCE;
            OPC_SYSTEM: cls = (funct3 == 3'b000) ? CLS_SYSTEM : CLS_ILLEGAL;
            default:    cls = CLS_ILLEGAL;
        endcase
    end

    // Per-class attribute flags used by the sequencer.
    always_comb begin
        writes_rd = cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
                                CLS_LOAD, CLS_OP_IMM, CLS_OP};
        is_mem    = cls inside {CLS_LOAD, CLS_STORE};
        is_store  = (cls == CLS_STORE);
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
//   clk      in  1      system clock, rising edge
//   reset    in  1      synchronous active-high reset
//   run      in  1      permits a new fetch (an instruction in flight always completes)
//   bus      master     memory handshakes, ir, br_taken and datapath strobes
//   halted   out 1      sticky halt (ECALL/EBREAK, illegal opcode, fetch timeout)
//   fault    out 2      halt cause: 0 ecall/ebreak, 1 illegal, 2 fetch timeout
//   instret  out CNT_W  retired-instruction count, wraps
// FETCH_TIMEOUT = max unanswered fetch-request cycles before halting; 0 disables it.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    cpu_ctrl_fsm_if.master   bus,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    localparam bit TIMEOUT_EN = (FETCH_TIMEOUT != 0);
    localparam int TO_W       = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    // Value of the wait counter on the last allowed unanswered cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [31:0]       ir_q;
    logic [TO_W-1:0]   to_cnt;
    logic              to_inc;
    logic              br_flag;
    fault_t            fault_q;
    fault_t            fault_next;
    logic              set_fault;
    logic              load_ir;
    logic              retire;
    logic [CNT_W-1:0]  instret_q;

    inst_class_t       cls;
    logic              writes_rd;
    logic              is_mem;
    logic              is_store;

    inst_class u_inst_class (
        .opcode    (ir_q[6:0]),
        .funct3    (ir_q[14:12]),
        .cls       (cls),
        .writes_rd (writes_rd),
        .is_mem    (is_mem),
        .is_store  (is_store)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode. Every strobe defaults low, so HALT and
    // the internal DECODE/EXEC cycles drive nothing onto the bus.
    always_comb begin
        next_state        = state;
        bus.imem_req      = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.dmem_we       = 1'b0;
        bus.rf_we         = 1'b0;
        bus.pc_en         = 1'b0;
        bus.pc_sel_target = 1'b0;
        load_ir           = 1'b0;
        retire            = 1'b0;
        to_inc            = 1'b0;
        set_fault         = 1'b0;
        fault_next        = FAULT_ECALL;
        case (state)
            ST_FETCH: begin
                bus.imem_req = run;
                if (run && bus.imem_ready) begin
                    load_ir    = 1'b1;
                    next_state = ST_DECODE;
                end else if (run && TIMEOUT_EN) begin
                    if (to_cnt == TO_LAST) begin
                        set_fault  = 1'b1;
                        fault_next = FAULT_TIMEOUT;
                        next_state = ST_HALT;
                    end else begin
                        to_inc = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_SYSTEM: begin
                        set_fault  = 1'b1;
                        fault_next = FAULT_ECALL;
                        next_state = ST_HALT;
                    end
                    CLS_ILLEGAL: begin
                        set_fault  = 1'b1;
                        fault_next = FAULT_ILLEGAL;
                        next_state = ST_HALT;
                    end
                    default: next_state = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                next_state = is_mem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = is_store;
                if (bus.dmem_ready) begin
                    next_state = ST_WB;
                end
            end
            ST_WB: begin
                // rd=x0 suppresses the write even for register-writing classes.
                bus.rf_we         = writes_rd && (ir_q[11:7] != 5'd0);
                bus.pc_en         = 1'b1;
                bus.pc_sel_target = (cls == CLS_JAL) || (cls == CLS_JALR) ||
                                    ((cls == CLS_BRANCH) && br_flag);
                retire            = 1'b1;
                next_state        = ST_FETCH;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    // Instruction register, loaded only on an accepted fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
        end else if (load_ir) begin
            ir_q <= bus.imem_inst;
        end
    end

    // Fetch wait counter. It clears whenever the sequencer is not going to
    // be in FETCH next cycle and simply holds while run is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (next_state != ST_FETCH) begin
            to_cnt <= '0;
        end else if (to_inc) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Branch condition is captured in EXEC so WB uses a stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_flag <= 1'b0;
        end else if (state == ST_EXEC) begin
            br_flag <= bus.br_taken;
        end
    end

    // Halt cause, written once on the transition into HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= FAULT_ECALL;
        end else if (set_fault) begin
            fault_q <= fault_next;
        end
    end

    // Retired-instruction counter, one step per WB, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.ir  = ir_q;
    assign halted  = (state == ST_HALT);
    assign fault   = fault_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed, self-checking bench for cpu_ctrl_fsm.
// A per-cycle reference model (phase-of-instruction bookkeeping driven by the
// instruction word) is compared against the DUT on every negedge, and hand-computed
// literal latencies/values pin the model. Built with CNT_W=4 so instret wrap is cheap.
module tb_cpu_ctrl_fsm;

    localparam int TB_CNT_W   = 4;
    localparam int TB_TIMEOUT = 4;

    localparam logic [31:0] I_ADDI    = 32'h00500093;
    localparam logic [31:0] I_ADDI_X0 = 32'h00000013;
    localparam logic [31:0] I_LW      = 32'h0000A103;
    localparam logic [31:0] I_SW      = 32'h0020A023;
    localparam logic [31:0] I_BEQ     = 32'h00000463;
    localparam logic [31:0] I_LUI     = 32'h000002B7;
    localparam logic [31:0] I_AUIPC   = 32'h00000317;
    localparam logic [31:0] I_JAL     = 32'h000000EF;
    localparam logic [31:0] I_JALR    = 32'h000100E7;
    localparam logic [31:0] I_ADD     = 32'h002081B3;
    localparam logic [31:0] I_FENCE1  = 32'h0000008F;
    localparam logic [31:0] I_ECALL   = 32'h00000073;
    localparam logic [31:0] I_EBREAK  = 32'h00100073;
    localparam logic [31:0] I_ALLONES = 32'hFFFFFFFF;
    localparam logic [31:0] I_CSRRW   = 32'h00001073;
    localparam logic [31:0] I_LOWBITS = 32'h00000090;
    localparam logic [31:0] GARBAGE   = 32'hDEADBEEF;

    logic                clk;
    logic                reset;
    logic                run;
    logic                halted;
    logic [1:0]          fault;
    logic [TB_CNT_W-1:0] instret;

    cpu_ctrl_fsm_if dut_if ();

    cpu_ctrl_fsm #(
        .CNT_W         (TB_CNT_W),
        .FETCH_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bus     (dut_if),
        .halted  (halted),
        .fault   (fault),
        .instret (instret)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cycle         = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit legal;
        bit ecall;
        bit is_mem;
        bit is_store;
        bit writes;
        bit jump;
        bit branch;
    } info_t;

    function automatic info_t classify(input logic [31:0] w);
        info_t r;
        r = '0;
        if (w[6:0] == 7'h37 || w[6:0] == 7'h17 || w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
            r.legal = 1; r.writes = 1;
        end else if (w[6:0] == 7'h6F || w[6:0] == 7'h67) begin
            r.legal = 1; r.writes = 1; r.jump = 1;
        end else if (w[6:0] == 7'h63) begin
            r.legal = 1; r.branch = 1;
        end else if (w[6:0] == 7'h03) begin
            r.legal = 1; r.is_mem = 1; r.writes = 1;
        end else if (w[6:0] == 7'h23) begin
            r.legal = 1; r.is_mem = 1; r.is_store = 1;
        end else if (w[6:0] == 7'h0F) begin
            r.legal = 1;
        end else if (w[6:0] == 7'h73 && w[14:12] == 3'd0) begin
            r.ecall = 1;
        end
        return r;
    endfunction

    bit          m_valid    = 0;
    bit          m_halted   = 0;
    int          m_fault    = 0;
    int          m_instret  = 0;
    logic [31:0] m_ir       = '0;
    int          m_age      = 0;   // 0 fetch, 1 decode, 2 exec, 3 memory/writeback
    bit          m_mem_done = 0;
    int          m_wait     = 0;
    bit          m_flag     = 0;

    // Compare against the model, then advance the model with the inputs the
    // DUT will sample at the coming posedge.
    initial begin : compare_proc
        info_t      ci;
        logic [5:0] exp_strobe;
        forever begin
            @(negedge clk);
            ci = classify(m_ir);
            if (m_valid) begin
                exp_strobe = '0;
                if (!m_halted) begin
                    if (m_age == 0) begin
                        exp_strobe[5] = run;
                    end else if (m_age == 3) begin
                        if (ci.is_mem && !m_mem_done) begin
                            exp_strobe[4] = 1'b1;
                            exp_strobe[3] = ci.is_store;
                        end else begin
                            exp_strobe[2] = ci.writes && (m_ir[11:7] != 5'd0);
                            exp_strobe[1] = 1'b1;
                            exp_strobe[0] = ci.jump || (ci.branch && m_flag);
                        end
                    end
                end
                checkOutput("strobes", 32'({dut_if.imem_req, dut_if.dmem_req, dut_if.dmem_we,
                                            dut_if.rf_we, dut_if.pc_en, dut_if.pc_sel_target}),
                            32'(exp_strobe));
                checkOutput("halted", 32'(halted), 32'(m_halted));
                checkOutput("fault", 32'(fault), m_fault);
                checkOutput("instret", 32'(instret), m_instret);
                checkOutput("ir", dut_if.ir, m_ir);
            end
            if (reset) begin
                m_valid = 1; m_halted = 0; m_fault = 0; m_instret = 0; m_ir = '0;
                m_age = 0; m_mem_done = 0; m_wait = 0; m_flag = 0;
            end else if (m_valid && !m_halted) begin
                if (m_age == 0) begin
                    if (run && dut_if.imem_ready) begin
                        m_ir = dut_if.imem_inst; m_age = 1; m_wait = 0;
                    end else if (run) begin
                        m_wait++;
                        if (m_wait == TB_TIMEOUT) begin
                            m_halted = 1; m_fault = 2;
                        end
                    end
                end else if (m_age == 1) begin
                    if (ci.ecall) begin
                        m_halted = 1; m_fault = 0;
                    end else if (!ci.legal) begin
                        m_halted = 1; m_fault = 1;
                    end else begin
                        m_age = 2;
                    end
                end else if (m_age == 2) begin
                    m_flag = dut_if.br_taken;
                    m_age  = 3;
                end else if (ci.is_mem && !m_mem_done) begin
                    if (dut_if.dmem_ready) m_mem_done = 1;
                end else begin
                    m_instret  = (m_instret + 1) % (1 << TB_CNT_W);
                    m_age      = 0;
                    m_mem_done = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input bit r, input bit i_ready, input logic [31:0] inst,
                                 input bit br, input bit d_ready);
        @(posedge clk);
        #1;
        reset                = 1'b0;
        run                  = r;
        dut_if.imem_ready    = i_ready;
        dut_if.imem_inst     = inst;
        dut_if.br_taken      = br;
        dut_if.dmem_ready    = d_ready;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset             = 1'b1;
        run               = 1'b0;
        dut_if.imem_ready = 1'b0;
        dut_if.dmem_ready = 1'b0;
        dut_if.br_taken   = 1'b0;
    endtask

    // One instruction from its fetch cycle (k=0) until its pc_en pulse.
    // br_taken is the requested value only in the EXEC cycle (k=2) and its
    // inverse elsewhere; dmem_ready pulses at k = 3 + mem_wait.
    task automatic runInstr(input logic [31:0] inst, input bit br, input int mem_wait,
                            output int cycles, output int req_cycles,
                            output bit we_seen, output bit rf_we, output bit sel);
        bit done;
        done = 0; cycles = 0; req_cycles = 0; we_seen = 0; rf_we = 0; sel = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            applyStimulus(1'b1, 1'b1, (k == 0) ? inst : GARBAGE, (k == 2) ? br : !br,
                          (k == 3 + mem_wait));
            @(negedge clk);
            if (dut_if.dmem_req) begin
                req_cycles++;
                we_seen = we_seen | dut_if.dmem_we;
            end
            if (dut_if.pc_en) begin
                done   = 1;
                cycles = k + 1;
                rf_we  = dut_if.rf_we;
                sel    = dut_if.pc_sel_target;
            end
        end
        if (!done) checkOutput("retire_bound", 32'd0, 32'd1);
    endtask

    task automatic runHalting(input logic [31:0] inst, input int exp_fault, input string name);
        applyStimulus(1'b1, 1'b1, inst, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({name, "_not_yet_halted"}, 32'(halted), 32'd0);
        applyStimulus(1'b1, 1'b1, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({name, "_halted"}, 32'(halted), 32'd1);
        checkOutput({name, "_fault"}, 32'(fault), exp_fault);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int  cyc, reqc;
        bit  we, rfw, sel;
        reset             = 1'b1;
        run               = 1'b0;
        dut_if.imem_ready = 1'b0;
        dut_if.imem_inst  = '0;
        dut_if.br_taken   = 1'b0;
        dut_if.dmem_ready = 1'b0;
        doReset();

        // Idle after reset with run low: nothing requested, everything cleared.
        applyStimulus(1'b0, 1'b1, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_imem_req", 32'(dut_if.imem_req), 32'd0);
        checkOutput("reset_ir", dut_if.ir, 32'd0);
        checkOutput("reset_instret", 32'(instret), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);

        // ADDI: pc_en in cycle 3, next request in cycle 4 with instret=1.
        runInstr(I_ADDI, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("addi_cycles", cyc, 4);
        checkOutput("addi_rf_we", 32'(rfw), 1);
        checkOutput("addi_sel", 32'(sel), 0);
        applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("addi_next_req", 32'(dut_if.imem_req), 1);
        checkOutput("addi_instret", 32'(instret), 1);

        // LW with 3 wait cycles: 4 request cycles, 8 cycles total.
        runInstr(I_LW, 1'b0, 3, cyc, reqc, we, rfw, sel);
        checkOutput("lw_cycles", cyc, 8);
        checkOutput("lw_req_cycles", reqc, 4);
        checkOutput("lw_we", 32'(we), 0);
        checkOutput("lw_rf_we", 32'(rfw), 1);

        runInstr(I_SW, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("sw_cycles", cyc, 5);
        checkOutput("sw_we", 32'(we), 1);
        checkOutput("sw_rf_we", 32'(rfw), 0);

        runInstr(I_BEQ, 1'b1, 0, cyc, reqc, we, rfw, sel);
        checkOutput("beq_taken_sel", 32'(sel), 1);
        checkOutput("beq_taken_rf_we", 32'(rfw), 0);
        runInstr(I_BEQ, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("beq_not_taken_sel", 32'(sel), 0);

        runInstr(I_LUI, 1'b0, 0, cyc, reqc, we, rfw, sel);
        runInstr(I_AUIPC, 1'b0, 0, cyc, reqc, we, rfw, sel);
        runInstr(I_JAL, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("jal_sel", 32'(sel), 1);
        checkOutput("jal_rf_we", 32'(rfw), 1);
        runInstr(I_JALR, 1'b0, 0, cyc, reqc, we, rfw, sel);
        runInstr(I_ADD, 1'b0, 0, cyc, reqc, we, rfw, sel);
        runInstr(I_FENCE1, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("fence_rf_we", 32'(rfw), 0);
        runInstr(I_ADDI_X0, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("addi_x0_rf_we", 32'(rfw), 0);

        // Reset while a load is waiting in MEM.
        applyStimulus(1'b1, 1'b1, I_LW, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) applyStimulus(1'b1, 1'b1, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mem_reset_pre_req", 32'(dut_if.dmem_req), 1);
        doReset();
        applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mem_reset_dmem_req", 32'(dut_if.dmem_req), 0);
        checkOutput("mem_reset_imem_req", 32'(dut_if.imem_req), 1);
        checkOutput("mem_reset_instret", 32'(instret), 0);
        runInstr(I_ADDI, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("mem_reset_resume_cycles", cyc, 4);

        // 16 more retirements wrap the 4-bit counter back to 1.
        for (int n = 0; n < 16; n++) runInstr(I_ADDI, 1'b0, 0, cyc, reqc, we, rfw, sel);
        applyStimulus(1'b0, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("instret_wrap", 32'(instret), 1);

        // Fetch wait states; ready while run is low must not be taken.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, GARBAGE, 1'b0, 1'b0);
        runInstr(I_ADDI, 1'b0, 0, cyc, reqc, we, rfw, sel);
        checkOutput("wait_fetch_cycles", cyc, 4);
        checkOutput("wait_fetch_ir", dut_if.ir, I_ADDI);

        // ECALL halts without retiring; run toggling does not restart.
        runHalting(I_ECALL, 0, "ecall");
        for (int k = 0; k < 20; k++) applyStimulus(k[0], 1'b1, I_ADDI, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("ecall_still_halted", 32'(halted), 1);
        checkOutput("ecall_instret", 32'(instret), 2);

        doReset();
        runHalting(I_EBREAK, 0, "ebreak");
        doReset();
        runHalting(I_ALLONES, 1, "illegal_ones");
        doReset();
        runHalting(I_CSRRW, 1, "illegal_csr");
        doReset();
        runHalting(I_LOWBITS, 1, "illegal_lowbits");

        // Timeout: request rises in cycle 0, halt visible in cycle 4.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("timeout_cycle3_halted", 32'(halted), 0);
        applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("timeout_halted", 32'(halted), 1);
        checkOutput("timeout_fault", 32'(fault), 2);

        // Wait counter holds while run is low: 3 + 1 unanswered cycles halt.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, GARBAGE, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold_timeout_halted", 32'(halted), 1);
        checkOutput("hold_timeout_fault", 32'(fault), 2);

        applyStimulus(1'b0, 1'b0, GARBAGE, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I datapath: pc, instr_memory, decoder, regfile, immediate mux and alu.
- Replaces free-running single-cycle operation with FETCH/DECODE/EXEC/MEM/WB sequencing and ready-based handshakes to instruction and data memory.
- Generates pc advance, instruction-register load and register-file write strobes.
- Halts on ECALL/EBREAK, illegal opcode or fetch timeout, and counts retired instructions.

Parameters:
- CNT_W, 32: width of the instret counter.
- FETCH_TIMEOUT, 255: max cycles imem_req may stay unanswered before a fetch fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  permits a new fetch; does not abort an instruction in flight.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- imem_inst  in  32  fetched instruction word.
- ir  out  32  latched instruction, feeds the decoder.
- br_taken  in  1  branch condition from the alu.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store when 1, load when 0; valid only with dmem_req.
- dmem_ready  in  1  data access complete.
- rf_we  out  1  regfile write strobe.
- pc_en  out  1  one-cycle pc update pulse.
- pc_sel_target  out  1  with pc_en: 1 loads the branch/jump target, 0 loads pc+4.
- halted  out  1  sticky halt.
- fault  out  2  halt cause: 0 ecall/ebreak, 1 illegal, 2 fetch timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, checked every cycle, overrides all state): state=FETCH; ir=0; instret=0; timeout counter=0.
  - All strobes 0: imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel_target.
  - halted=0, fault=0.
  - A request in flight is abandoned; memories must tolerate a dropped req.
- FETCH:
  - imem_req=run.
  - imem_req is held until imem_ready. The same-cycle combination imem_req&imem_ready loads ir<=imem_inst and moves to DECODE.
  - imem_ready while imem_req=0 is ignored.
  - Timeout counter increments each cycle with imem_req=1 and no ready. On reaching FETCH_TIMEOUT the block goes to HALT with fault=2.
  - Counter clears on leaving FETCH.
  - If run drops while waiting, imem_req drops and the counter holds.
- DECODE, 1 cycle: classify ir[6:0].
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and FENCE (FENCE treated as NOP) go to EXEC.
  - SYSTEM with funct3=0 (ECALL/EBREAK) goes to HALT with fault=0.
  - Any other opcode, or ir[1:0]!=2'b11, goes to HALT with fault=1.
- EXEC, 1 cycle: LOAD and STORE go to MEM; all other classes go to WB. br_taken is sampled here into a branch flag.
- MEM:
  - dmem_req=1 and dmem_we=(STORE), both held until dmem_ready, then go to WB.
  - dmem_req never overlaps imem_req.
- WB, 1 cycle, then FETCH:
  - rf_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP.
  - rf_we=0 for BRANCH, STORE and FENCE.
  - rf_we=0 if ir[11:7]==0. This gating is redundant with x0 handling but is required.
  - pc_en=1.
  - pc_sel_target=1 for JAL, JALR, or BRANCH with the latched flag set.
  - instret increments and wraps modulo 2^CNT_W.
- HALT:
  - halted=1; fault stable; all strobes 0.
  - The halting instruction does not retire.
  - Only reset leaves HALT; run is ignored.
- Latency with zero-wait memories: 4 cycles per ALU/branch/jump instruction, 5 per load/store, plus memory wait cycles.
- Exactly one pc_en pulse per retired instruction.
- rf_we and pc_en are asserted only in WB.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - RV32I opcode constants (OPC_LUI … OPC_SYSTEM).
  - State encoding: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - Instruction-class enum.
  - Fault codes.
- One natural sub-module: inst_class, a combinational map of ir to class plus writes_rd, is_mem and is_store flags. The FSM, timeout counter and instret stay in cpu_ctrl_fsm.

Test Plan:
- Reset, run=1, imem_ready=1 always, ADDI x1,x0,5 (0x00500093):
  - imem_req in cycle 0.
  - rf_we and pc_en in cycle 3.
  - pc_sel_target=0; instret=1.
  - Next imem_req in cycle 4.
- LW x2,0(x1) (0x0000A103) with dmem_ready delayed 3 cycles:
  - dmem_req=1 and dmem_we=0 held for 4 cycles.
  - rf_we one cycle after dmem_ready.
  - Total 8 cycles.
- SW (0x0020A023) -> dmem_we=1 and rf_we=0 in WB. BEQ (0x00000463) with br_taken=1 -> pc_sel_target=1, rf_we=0. Same BEQ with br_taken=0 -> pc_sel_target=0.
- ECALL (0x00000073) -> halted=1 and fault=0 after DECODE. instret is unchanged, no pc_en, and halted holds with run toggled for 20 cycles.
- Illegal word 0xFFFFFFFF -> fault=1. With FETCH_TIMEOUT=4 and imem_ready=0 -> fault=2 exactly 4 cycles after imem_req rises.
- Reset asserted during MEM (dmem_req=1):
  - Next cycle dmem_req=0, state FETCH, instret=0.
  - Execution then resumes normally.
